floor_depth_sequencer: RTL and testbench
========================================

# floor_depth_sequencer

Per-scanline control stage that sits directly upstream of the `serial_divider` and also consumes its result. At each line start it forms the floor-plane depth division K / (vpos − HORIZON), drives the divider handshake, and latches the 8-bit quotient as the line's depth. During active video it accumulates that depth into a horizontal texture coordinate for the pixel pipeline.

## Interface
Parameters:
- DIVIDEND_WIDTH, 16, divider dividend width (matches divider)
- DIVISOR_WIDTH, 8, divider divisor and quotient width (matches divider)
- DEPTH_K, 16'd12288, constant dividend
- HORIZON, 10'd240, horizon scanline; lines ≤ HORIZON are sky
- TIMEOUT, 32, WAIT-state cycle limit (used only with DEPTH_TIMEOUT_EN)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- line_start  in  1  one-cycle pulse at hblank start
- vpos  in  10  current line, sampled on line_start
- pixel_tick  in  1  one pulse per active pixel
- div_start  out  1  divider start pulse
- div_dividend  out  16  divider dividend
- div_divisor  out  8  divider divisor
- div_quotient  in  8  divider quotient
- div_done  in  1  divider done
- depth  out  8  latched line depth
- depth_valid  out  1  depth valid for the current line
- sky  out  1  current line is at or above the horizon
- tex_u  out  8  equals u_acc[15:8]
- div_err  out  1  sticky timeout flag

## Operation
- FSM states: IDLE, ISSUE, ARM, WAIT.
- On line_start, from any state:
  - Compute dy = vpos − HORIZON as a signed value.
  - Clear u_acc, depth_valid and sky.
  - Any in-flight division is abandoned; its result is never latched.
- dy ≤ 0:
  - sky=1, depth=0, depth_valid=1, go to IDLE.
  - The divider is not started.
- 0 < dy and {dy,8'b0} ≤ DEPTH_K (quotient would overflow 8 bits):
  - depth=8'hFF, depth_valid=1, go to IDLE.
  - The divider is not started.
- Otherwise:
  - div_divisor = min(dy,255), div_dividend = DEPTH_K.
  - Go to ISSUE.
- ISSUE: div_start=1 for exactly this cycle, then go to ARM.
- ARM: one cycle with div_done ignored, then go to WAIT. The divider holds done=1 from its previous operation until it samples start, so done must not be sampled in this cycle.
- WAIT: on div_done=1, latch depth ← div_quotient, set depth_valid=1, go to IDLE.
- div_dividend and div_divisor are held stable from ISSUE until WAIT exits.
- pixel_tick:
  - When depth_valid=1 and sky=0: u_acc ← u_acc + {8'b0, depth}, 16-bit, wrapping mod 2^16.
  - Otherwise u_acc holds.
- line_start and pixel_tick in the same cycle: line_start wins and u_acc is cleared.
- Reset values: state IDLE, all outputs 0, u_acc=0.
- Reset mid-operation returns to IDLE with no pending start.

## Timing
- div_start asserts the cycle after line_start.
- With a 16-bit dividend the divider raises done 18 cycles after div_start; depth_valid then rises on the next edge.
- Worst case from line_start to depth_valid is ≤ 22 cycles, which fits inside hblank.
- Sky and saturate cases: depth_valid rises on the edge after line_start.
- depth changes only on a latch or on line_start; it is stable for the whole line.

## Configuration
- DEPTH_TIMEOUT_EN defined:
  - A 6-bit counter runs in WAIT.
  - After TIMEOUT cycles without div_done: depth=8'hFF, depth_valid=1, div_err=1 (sticky until rst), go to IDLE.
- DEPTH_TIMEOUT_EN undefined:
  - No counter; WAIT waits indefinitely.
  - div_err is tied to 0.

## Test plan
- Reset: assert rst mid-WAIT → all outputs 0, state IDLE, no div_start after release until the next line_start.
- vpos=300 (dy=60) with a behavioural divider → one div_start pulse with div_divisor=60 and div_dividend=12288; depth=204 and depth_valid=1 within 22 cycles. Stale div_done=1 during ARM is ignored.
- Horizon and overflow boundaries:
  - vpos=240 → sky=1, depth=0.
  - vpos=288 (dy=48) → depth=255, no div_start.
  - vpos=289 (dy=49) → depth=250.
  - vpos=1000 → div_divisor=255, depth=48.
- Second line_start 5 cycles into WAIT with vpos=400 → new div_start; final depth=76 (12288/160). The first result is never visible.
- depth=204, 10 pixel_ticks → u_acc=2040, tex_u=7. Tick coincident with line_start → u_acc=0.
- DEPTH_TIMEOUT_EN with div_done stuck at 0 → depth=255, div_err=1 after 32 WAIT cycles. Without the macro, depth_valid stays 0.

Source files
------------

// File: rtl/floor_depth_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | floor_depth_sequencer                                                      |
// | Per-line floor depth K/(vpos-HORIZON) via serial_divider, plus texture U.  |
// | Optional macro: DEPTH_TIMEOUT_EN (WAIT-state timeout with sticky div_err). |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

module floor_depth_sequencer #(
  parameter int                        DIVIDEND_WIDTH = 16,
  parameter int                        DIVISOR_WIDTH  = 8,
  parameter logic [DIVIDEND_WIDTH-1:0] DEPTH_K        = 16'd12288,
  parameter logic [9:0]                HORIZON        = 10'd240,
  parameter int                        TIMEOUT        = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      line_start,
  input  logic [9:0]                vpos,
  input  logic                      pixel_tick,
  output logic                      div_start,
  output logic [DIVIDEND_WIDTH-1:0] div_dividend,
  output logic [DIVISOR_WIDTH-1:0]  div_divisor,
  input  logic [DIVISOR_WIDTH-1:0]  div_quotient,
  input  logic                      div_done,
  output logic [7:0]                depth,
  output logic                      depth_valid,
  output logic                      sky,
  output logic [7:0]                tex_u,
  output logic                      div_err
);

  localparam int c_CMP_W = (DIVIDEND_WIDTH > 18) ? DIVIDEND_WIDTH : 18;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_ARM   = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  state_t                    r_state;
  logic                      r_div_start;
  logic [DIVIDEND_WIDTH-1:0] r_dividend;
  logic [DIVISOR_WIDTH-1:0]  r_divisor;
  logic [7:0]                r_depth;
  logic                      r_depth_valid;
  logic                      r_sky;
  logic [15:0]               r_u_acc;

  logic signed [10:0]        w_dy;
  logic [9:0]                w_dy_mag;
  logic                      w_sky;
  logic [c_CMP_W-1:0]        w_scaled;
  logic [c_CMP_W-1:0]        w_k;
  logic                      w_sat;
  logic [DIVISOR_WIDTH-1:0]  w_divisor;

  assign w_dy     = $signed({1'b0, vpos}) - $signed({1'b0, HORIZON});
  assign w_dy_mag = w_dy[9:0];
  assign w_sky    = w_dy[10] | (w_dy == 11'sd0);
  // A quotient of 256 or more cannot be represented, so saturate without dividing.
  assign w_scaled = c_CMP_W'({w_dy_mag, 8'h00});
  assign w_k      = c_CMP_W'(DEPTH_K);
  assign w_sat    = (w_scaled <= w_k);
  assign w_divisor = (w_dy_mag > 10'd255) ? DIVISOR_WIDTH'(8'hFF)
                                          : DIVISOR_WIDTH'(w_dy_mag[7:0]);

`ifdef DEPTH_TIMEOUT_EN
  logic [5:0] r_tcnt;
  logic       r_div_err;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_div_start   <= 1'b0;
      r_dividend    <= '0;
      r_divisor     <= '0;
      r_depth       <= 8'h00;
      r_depth_valid <= 1'b0;
      r_sky         <= 1'b0;
      r_u_acc       <= 16'h0000;
`ifdef DEPTH_TIMEOUT_EN
      r_tcnt        <= 6'd0;
      r_div_err     <= 1'b0;
`endif
    end else begin
      r_div_start <= 1'b0;
      if (line_start) begin
        // A new line abandons whatever division was in flight.
        r_u_acc       <= 16'h0000;
        r_depth_valid <= 1'b0;
        r_sky         <= 1'b0;
        if (w_sky) begin
          r_sky         <= 1'b1;
          r_depth       <= 8'h00;
          r_depth_valid <= 1'b1;
          r_state       <= S_IDLE;
        end else if (w_sat) begin
          r_depth       <= 8'hFF;
          r_depth_valid <= 1'b1;
          r_state       <= S_IDLE;
        end else begin
          r_divisor   <= w_divisor;
          r_dividend  <= DEPTH_K;
          r_div_start <= 1'b1;
          r_state     <= S_ISSUE;
        end
      end else begin
        if (pixel_tick && r_depth_valid && !r_sky) begin
          r_u_acc <= r_u_acc + {8'h00, r_depth};
        end
        case (r_state)
          S_IDLE:  r_state <= S_IDLE;
          S_ISSUE: r_state <= S_ARM;
          // The divider still shows done from its previous job here.
          S_ARM: begin
            r_state <= S_WAIT;
`ifdef DEPTH_TIMEOUT_EN
            r_tcnt  <= 6'd0;
`endif
          end
          S_WAIT: begin
            if (div_done) begin
              r_depth       <= div_quotient[7:0];
              r_depth_valid <= 1'b1;
              r_state       <= S_IDLE;
`ifdef DEPTH_TIMEOUT_EN
            end else if (r_tcnt == 6'(TIMEOUT - 1)) begin
              r_depth       <= 8'hFF;
              r_depth_valid <= 1'b1;
              r_div_err     <= 1'b1;
              r_state       <= S_IDLE;
            end else begin
              r_tcnt <= r_tcnt + 6'd1;
`endif
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign div_start    = r_div_start;
  assign div_dividend = r_dividend;
  assign div_divisor  = r_divisor;
  assign depth        = r_depth;
  assign depth_valid  = r_depth_valid;
  assign sky          = r_sky;
  assign tex_u        = r_u_acc[15:8];
`ifdef DEPTH_TIMEOUT_EN
  assign div_err      = r_div_err;
`else
  assign div_err      = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_floor_depth_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_floor_depth_sequencer                                                   |
// | Scoreboard bench with a behavioural serial divider. Honours DEPTH_TIMEOUT_EN.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

module tb_floor_depth_sequencer;

  logic        clk        = 1'b0;
  logic        rst        = 1'b1;
  logic        line_start = 1'b0;
  logic [9:0]  vpos       = 10'd0;
  logic        pixel_tick = 1'b0;
  logic        div_start;
  logic [15:0] div_dividend;
  logic [7:0]  div_divisor;
  logic [7:0]  div_quotient;
  logic        div_done;
  logic [7:0]  depth;
  logic        depth_valid;
  logic        sky;
  logic [7:0]  tex_u;
  logic        div_err;

  floor_depth_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .line_start   (line_start),
    .vpos         (vpos),
    .pixel_tick   (pixel_tick),
    .div_start    (div_start),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_quotient (div_quotient),
    .div_done     (div_done),
    .depth        (depth),
    .depth_valid  (depth_valid),
    .sky          (sky),
    .tex_u        (tex_u),
    .div_err      (div_err)
  );

  always #5 clk = ~clk;

  // Behavioural divider: start is registered once, so done from the previous
  // job stays high through the sequencer's ARM cycle.
  logic [15:0] m_a;
  logic [7:0]  m_b;
  logic        m_go;
  int          m_cnt;
  bit          stuck = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      div_done     <= 1'b1;
      div_quotient <= 8'h11;
      m_go         <= 1'b0;
      m_cnt        <= 0;
    end else begin
      m_go <= div_start;
      if (m_go) begin
        div_done <= 1'b0;
        m_cnt    <= 16;
        m_a      <= div_dividend;
        m_b      <= div_divisor;
      end else if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1 && !stuck) begin
          div_done     <= 1'b1;
          div_quotient <= 8'(m_a / {8'h00, m_b});
        end
      end
    end
  end

  int          n_chk   = 0;
  int          n_fail  = 0;
  int          n_starts = 0;
  bit          prev_start = 1'b0;
  logic [7:0]  q_depth[$];
  logic [7:0]  q_div[$];
  logic [7:0]  m_e;

  function automatic bit exp_divides(input int v);
    int dy;
    dy = v - 240;
    return (dy > 0) && (dy * 256 > 12288);
  endfunction

  function automatic logic [7:0] exp_depth(input int v);
    int dy;
    dy = v - 240;
    if (dy <= 0) return 8'h00;
    if (dy * 256 <= 12288) return 8'hFF;
    if (dy > 255) dy = 255;
    return 8'(12288 / dy);
  endfunction

  function automatic logic [7:0] exp_divisor(input int v);
    int dy;
    dy = v - 240;
    if (dy > 255) dy = 255;
    return 8'(dy);
  endfunction

  // Scoreboard: checks each div_start against its queued operands and the first
  // valid depth of each line against the queued expected depth.
  always begin
    @(posedge clk);
    #3;
    if (!rst) begin
      if (div_start) begin
        n_starts++;
        n_chk++;
        if (prev_start) begin
          n_fail++;
          $display("FAIL div_start_width: div_start high for 2 cycles, required 1");
        end else if (q_div.size() == 0) begin
          n_fail++;
          $display("FAIL div_start_unexpected: got div_start=1, required 0");
        end else begin
          m_e = q_div.pop_front();
          if (div_divisor !== m_e || div_dividend !== 16'd12288) begin
            n_fail++;
            $display("FAIL div_operands: got %0d/%0d, required 12288/%0d",
                     div_dividend, div_divisor, m_e);
          end
        end
      end
      prev_start = div_start;
      if (depth_valid && q_depth.size() > 0) begin
        m_e = q_depth.pop_front();
        n_chk++;
        if (depth !== m_e) begin
          n_fail++;
          $display("FAIL sb_depth: got %0d, required %0d", depth, m_e);
        end
      end
    end else begin
      prev_start = 1'b0;
    end
  end

  task automatic pulse_line(input int v, input bit tick);
    @(negedge clk);
    q_depth.delete();
    if (exp_divides(v)) q_div.push_back(exp_divisor(v));
    vpos       = 10'(v);
    line_start = 1'b1;
    pixel_tick = tick;
    @(negedge clk);
    line_start = 1'b0;
    pixel_tick = 1'b0;
    q_depth.push_back(exp_depth(v));
  endtask

  task automatic wait_valid(input int max, output int k);
    k = 1;
    while (!depth_valid && k < max) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      @(negedge clk);
      pixel_tick = 1'b1;
      @(negedge clk);
      pixel_tick = 1'b0;
    end
  endtask

  task automatic test_reset();
    int s;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({div_start, div_dividend, div_divisor, depth, depth_valid, sky, tex_u, div_err} !== 52'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got nonzero outputs (depth=%0d valid=%0d), required all 0",
               depth, depth_valid);
    end
    rst = 1'b0;
    pulse_line(300, 1'b0);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if ({div_start, div_dividend, div_divisor, depth, depth_valid, sky, tex_u, div_err} !== 52'd0) begin
      n_fail++;
      $display("FAIL reset_mid_wait: got divisor=%0d dividend=%0d, required all outputs 0",
               div_divisor, div_dividend);
    end
    q_div.delete();
    q_depth.delete();
    @(negedge clk);
    rst = 1'b0;
    s = n_starts;
    repeat (25) @(negedge clk);
    n_chk++;
    if (n_starts != s || depth_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_restart: got %0d starts valid=%0d, required 0 starts valid=0",
               n_starts - s, depth_valid);
    end
  endtask

  task automatic test_divide();
    int s, k;
    for (int rep = 0; rep < 2; rep++) begin
      s = n_starts;
      pulse_line(300, 1'b0);
      n_chk++;
      if (depth_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL divide_valid_clear: got valid=%0d, required 0", depth_valid);
      end
      wait_valid(22, k);
      n_chk++;
      if (depth_valid !== 1'b1 || depth !== 8'd204 || k < 3) begin
        n_fail++;
        $display("FAIL divide_300: got valid=%0d depth=%0d after %0d cycles, required 204 within 3..22",
                 depth_valid, depth, k);
      end
      n_chk++;
      if (n_starts - s != 1 || div_divisor !== 8'd60 || sky !== 1'b0) begin
        n_fail++;
        $display("FAIL divide_start: got %0d starts divisor=%0d sky=%0d, required 1 start divisor=60 sky=0",
                 n_starts - s, div_divisor, sky);
      end
    end
  endtask

  task automatic test_boundaries();
    int         vs[5]  = '{240, 288, 289, 1000, 100};
    logic [7:0] ed[5]  = '{8'd0, 8'd255, 8'd250, 8'd48, 8'd0};
    bit         es[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    int         est[5] = '{0, 0, 1, 1, 0};
    int s, k;
    for (int i = 0; i < 5; i++) begin
      s = n_starts;
      pulse_line(vs[i], 1'b0);
      wait_valid(22, k);
      n_chk++;
      if (depth_valid !== 1'b1 || depth !== ed[i]) begin
        n_fail++;
        $display("FAIL bound_depth vpos=%0d: got valid=%0d depth=%0d, required %0d",
                 vs[i], depth_valid, depth, ed[i]);
      end
      n_chk++;
      if (sky !== es[i] || n_starts - s != est[i]) begin
        n_fail++;
        $display("FAIL bound_flags vpos=%0d: got sky=%0d starts=%0d, required sky=%0d starts=%0d",
                 vs[i], sky, n_starts - s, es[i], est[i]);
      end
      if (est[i] == 0) begin
        n_chk++;
        if (k != 1) begin
          n_fail++;
          $display("FAIL bound_latency vpos=%0d: got %0d cycles, required 1", vs[i], k);
        end
      end
    end
  endtask

  task automatic test_abandon();
    int s, k;
    bit changed;
    s = n_starts;
    pulse_line(300, 1'b0);
    repeat (6) @(negedge clk);
    pulse_line(400, 1'b0);
    wait_valid(22, k);
    n_chk++;
    if (depth_valid !== 1'b1 || depth !== 8'd76 || n_starts - s != 2) begin
      n_fail++;
      $display("FAIL abandon: got valid=%0d depth=%0d starts=%0d, required depth=76 starts=2",
               depth_valid, depth, n_starts - s);
    end
    changed = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (depth !== 8'd76 || depth_valid !== 1'b1) changed = 1'b1;
    end
    n_chk++;
    if (changed) begin
      n_fail++;
      $display("FAIL abandon_stable: got depth=%0d, required 76 held all line", depth);
    end
  endtask

  task automatic test_texture();
    int k;
    pulse_line(300, 1'b0);
    wait_valid(22, k);
    pulse_line(300, 1'b0);
    ticks(5);
    wait_valid(22, k);
    ticks(10);
    n_chk++;
    if (tex_u !== 8'd7) begin
      n_fail++;
      $display("FAIL tex_10_ticks: got tex_u=%0d, required 7", tex_u);
    end
    ticks(2);
    n_chk++;
    if (tex_u !== 8'd9) begin
      n_fail++;
      $display("FAIL tex_12_ticks: got tex_u=%0d, required 9", tex_u);
    end
    pulse_line(300, 1'b1);
    n_chk++;
    if (tex_u !== 8'd0) begin
      n_fail++;
      $display("FAIL tex_coincident_clear: got tex_u=%0d, required 0", tex_u);
    end
    wait_valid(22, k);
    ticks(2);
    n_chk++;
    if (tex_u !== 8'd1) begin
      n_fail++;
      $display("FAIL tex_after_coincident: got tex_u=%0d, required 1", tex_u);
    end
    pulse_line(288, 1'b0);
    ticks(3);
    n_chk++;
    if (tex_u !== 8'd2) begin
      n_fail++;
      $display("FAIL tex_saturated: got tex_u=%0d, required 2", tex_u);
    end
  endtask

  task automatic test_timeout();
    int k;
    stuck = 1'b1;
    pulse_line(300, 1'b0);
`ifdef DEPTH_TIMEOUT_EN
    q_depth.delete();
    q_depth.push_back(8'hFF);
    wait_valid(40, k);
    n_chk++;
    if (depth_valid !== 1'b1 || depth !== 8'hFF || div_err !== 1'b1 || k < 33 || k > 37) begin
      n_fail++;
      $display("FAIL timeout: got valid=%0d depth=%0d err=%0d at %0d cycles, required 255 err=1 at ~35",
               depth_valid, depth, div_err, k);
    end
`else
    repeat (60) @(negedge clk);
    n_chk++;
    if (depth_valid !== 1'b0 || div_err !== 1'b0) begin
      n_fail++;
      $display("FAIL no_timeout: got valid=%0d err=%0d, required 0 0", depth_valid, div_err);
    end
`endif
    stuck = 1'b0;
    pulse_line(300, 1'b0);
    wait_valid(22, k);
    n_chk++;
`ifdef DEPTH_TIMEOUT_EN
    if (depth !== 8'd204 || depth_valid !== 1'b1 || div_err !== 1'b1) begin
`else
    if (depth !== 8'd204 || depth_valid !== 1'b1 || div_err !== 1'b0) begin
`endif
      n_fail++;
      $display("FAIL timeout_recover: got depth=%0d valid=%0d err=%0d, required 204 1 sticky-err",
               depth, depth_valid, div_err);
    end
  endtask

  initial begin
    test_reset();
    test_divide();
    test_boundaries();
    test_abandon();
    test_texture();
    test_timeout();
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
